upload_packer: RTL and testbench
================================

UPLOAD_PACKER -- requirements
Module: upload_packer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, meaning the maximum payload bytes per frame (range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning the number of idle cycles that closes an open packet.
REQ-003 SHALL have the port clk, input, width 1: the single clock; all logic uses its rising edge.
REQ-004 SHALL have the port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have the port upload_req, input, width 1: the handler requests to upload.
REQ-006 SHALL have the port upload_data, input, width 8: the upload byte.
REQ-007 SHALL have the port upload_source, input, width 8: the source identifier of the byte.
REQ-008 SHALL have the port upload_valid, input, width 1: the upload byte is valid.
REQ-009 SHALL have the port upload_ready, output, width 1: the packer accepts a byte this cycle.
REQ-010 SHALL have the port tx_data, output, width 8: the framed byte to the transport.
REQ-011 SHALL have the port tx_valid, output, width 1: tx_data is valid.
REQ-012 SHALL have the port tx_ready, input, width 1: the transport accepts tx_data.

Function
REQ-013 SHALL accept an upload byte on a cycle where upload_valid and upload_ready are both 1; upload_valid without upload_ready has no effect.
REQ-014 SHALL drive upload_ready = (state==COLLECT) && (count<MAX_PAYLOAD) && (count==0 || upload_source==cur_src).
- upload_ready is combinational from registered state and upload_source.
REQ-015 SHALL, on the first accepted byte of a packet (count==0), latch cur_src = upload_source and start the checksum at upload_source.
REQ-016 SHALL, for each accepted byte, write it to buffer[count], increment count, and add it to the 8-bit checksum (wrap mod 256).
REQ-017 SHALL keep an idle counter that clears on any accepted byte or while upload_req==1, and otherwise increments, saturating at GAP_CYCLES.
REQ-018 SHALL close the packet when count>0 and any of these holds:
- count reaches MAX_PAYLOAD;
- the idle counter reaches GAP_CYCLES;
- upload_valid==1 with upload_source!=cur_src.
REQ-019 SHALL, on close, fold count_hi (always 0x00) and count_lo into the checksum and go to HDR0 on the next cycle.
REQ-020 SHALL transmit the frame in this order: 0xAA, 0x44, cur_src, 0x00, count[7:0], payload[0..count-1], checksum.
- Checksum = (src + len_hi + len_lo + sum of payload) mod 256.
REQ-021 SHALL use the states COLLECT, HDR0, HDR1, SRC, LENH, LENL, PAYLOAD, CSUM.
- Each transmit state advances only on tx_valid && tx_ready.
- PAYLOAD repeats until rd_idx==count-1.
- CSUM returns to COLLECT with count, idle counter and checksum cleared.
REQ-022 SHALL hold tx_valid=1 and tx_data stable in every transmit state until tx_ready; tx_valid=0 in COLLECT.
REQ-023 SHALL deassert upload_ready throughout transmission; a byte from a differing source waits and begins the next packet after CSUM.
REQ-024 SHALL never emit a frame with count==0; idle with an empty buffer produces no output.
REQ-025 SHALL let tx_ready stalls of any length only extend the frame, with no byte loss or duplication.
REQ-026 SHALL have a minimum latency from close to the first tx_valid of 1 cycle.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set state=COLLECT, count=0, idle=0, checksum=0, cur_src=0x00, tx_valid=0, tx_data=0x00, rd_idx=0.
REQ-028 SHALL, on reset mid-frame, abandon the partial frame and buffered payload; after release upload_ready=1 on the first clock.
REQ-029 SHALL NOT reset the buffer contents.

Structure
REQ-030 SHALL put the constants SYNC0=0xAA and SYNC1=0x44 and the state enum in a shared package, upload_pkg, which the DSM handler source IDs (0x03 etc.) also use.
REQ-031 SHALL implement the payload store as sub-module upload_payload_buf: a MAX_PAYLOAD x 8 simple dual-port RAM with one write port and a registered read, with read prefetched one cycle ahead of PAYLOAD.

Verification
REQ-032 SHALL cover: source 0x03 sends 9 bytes 00,12,34,00,56,00,68,1F,40 then idle -> frame AA 44 03 00 09 00 12 34 00 56 00 68 1F 40 checksum, emitted after 16 idle cycles.
REQ-033 SHALL cover: 64 consecutive bytes 0x01 from source 0x03 -> frame closes at count 64 with length bytes 00 40, checksum=(03+40+40)=0x83, and upload_ready=0 at count 64.
REQ-034 SHALL cover: two bytes from source 0x03 then a valid byte from source 0x05 -> frame for 0x03 with len 2 sent, then the 0x05 byte accepted into a new packet.
REQ-035 SHALL cover: tx_ready toggling 1-in-3 during a 9-byte frame -> identical byte sequence, tx_data stable while stalled.
REQ-036 SHALL cover: rst_n low during PAYLOAD -> tx_valid=0 immediately; after release no remnant bytes appear and a new 1-byte frame AA 44 03 00 01 7E checksum=0x82.
REQ-037 SHALL cover: upload_req held high with no valid for 100 cycles after 3 bytes -> no close until req drops plus 16 cycles.

Source files
------------

// File: rtl/upload_pkg.sv
// Shared constants and transmit state encoding for the upload packer and
// the DSM handlers that feed it.
package upload_pkg;

    localparam logic [7:0] SYNC0   = 8'hAA;
    localparam logic [7:0] SYNC1   = 8'h44;
    localparam logic [7:0] SRC_DSM = 8'h03;

    typedef enum logic [2:0] {
        COLLECT,
        HDR0,
        HDR1,
        SRC,
        LENH,
        LENL,
        PAYLOAD,
        CSUM
    } pk_state_t;

endpackage

// File: rtl/upload_payload_buf.sv
// Payload store: simple dual-port RAM, one write port, registered read.
// Contents are deliberately not reset.
module upload_payload_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/upload_packer.sv
// Collects upload bytes from one source into a packet and frames it as
// AA 44 src 00 len payload checksum towards the transport.
module upload_packer
    import upload_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upload_req,
    input  logic [7:0] upload_data,
    input  logic [7:0] upload_source,
    input  logic       upload_valid,
    output logic       upload_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int unsigned AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0]  MAX_CNT = 8'(MAX_PAYLOAD);
    localparam logic [15:0] GAP_CNT = 16'(GAP_CYCLES);

    pk_state_t     state, state_nxt;
    logic [7:0]    count, csum, cur_src, rd_idx;
    logic [15:0]   idle;
    logic [7:0]    rd_data, cnt_nxt, byte_sum;
    logic [AW-1:0] rd_addr;
    logic          accept, tx_fire, close, last_pay;

    assign upload_ready = (state == COLLECT) && (count < MAX_CNT) &&
                          ((count == 8'd0) || (upload_source == cur_src));
    assign accept   = upload_valid && upload_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign last_pay = (rd_idx == count - 8'd1);
    assign cnt_nxt  = count + {7'd0, accept};
    assign byte_sum = ((count == 8'd0) ? upload_source : csum) +
                      (accept ? upload_data : 8'h00);
    assign close    = (state == COLLECT) && (count != 8'd0) &&
                      ((count == MAX_CNT) || (idle == GAP_CNT) ||
                       (upload_valid && (upload_source != cur_src)));

    // Read address runs one ahead on a PAYLOAD handshake so the registered
    // read already holds the next byte when the state machine gets there.
    assign rd_addr = (state == PAYLOAD && tx_fire) ? AW'(rd_idx + 8'd1) : rd_idx[AW-1:0];

    upload_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (count[AW-1:0]),
        .wr_data (upload_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (close)   state_nxt = HDR0;
            HDR0:    if (tx_fire) state_nxt = HDR1;
            HDR1:    if (tx_fire) state_nxt = SRC;
            SRC:     if (tx_fire) state_nxt = LENH;
            LENH:    if (tx_fire) state_nxt = LENL;
            LENL:    if (tx_fire) state_nxt = PAYLOAD;
            PAYLOAD: if (tx_fire && last_pay) state_nxt = CSUM;
            CSUM:    if (tx_fire) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        tx_valid = (state != COLLECT);
        tx_data  = 8'h00;
        case (state)
            HDR0:    tx_data = SYNC0;
            HDR1:    tx_data = SYNC1;
            SRC:     tx_data = cur_src;
            LENH:    tx_data = 8'h00;
            LENL:    tx_data = count;
            PAYLOAD: tx_data = rd_data;
            CSUM:    tx_data = csum;
            default: tx_data = 8'h00;
        endcase
    end

    // A byte accepted on the same cycle an idle timeout closes is folded
    // into the closing packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            idle    <= '0;
            csum    <= '0;
            cur_src <= '0;
            rd_idx  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    count <= cnt_nxt;
                    if (accept && count == 8'd0) cur_src <= upload_source;
                    if (accept || upload_req)    idle <= '0;
                    else if (idle < GAP_CNT)     idle <= idle + 16'd1;
                    if (close)       csum <= byte_sum + cnt_nxt;
                    else if (accept) csum <= byte_sum;
                end
                PAYLOAD: begin
                    if (tx_fire) rd_idx <= last_pay ? 8'd0 : rd_idx + 8'd1;
                end
                CSUM: begin
                    if (tx_fire) begin
                        count <= '0;
                        idle  <= '0;
                        csum  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_upload_packer.sv
// Directed bench for upload_packer: table of single-packet frames plus
// hand-written sequences for length limit, source change, req hold and reset.
module tb_upload_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    always #5 clk = ~clk;

    upload_packer #(
        .MAX_PAYLOAD (64),
        .GAP_CYCLES  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .upload_req    (upload_req),
        .upload_data   (upload_data),
        .upload_source (upload_source),
        .upload_valid  (upload_valid),
        .upload_ready  (upload_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready)
    );

    typedef struct packed {
        logic [7:0]       src;
        int               len;
        logic [15:0][7:0] pay;
        bit               stall;
        logic [7:0]       csum;
    } vec_t;

    vec_t       tbl [5];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         stall_mode = 1'b0;
    bit         hold_pending = 1'b0;
    logic [7:0] hold_data;
    bit         last_acc, last_valid, last_rdy;
    logic [7:0] rxq [$];
    logic [7:0] expq [$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %02h required %02h", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, transfer at next posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic [7:0] s, input logic rq);
        logic rdy;
        @(negedge clk);
        rdy = !stall_mode || (cyc % 3 == 0);
        cyc++;
        upload_valid  = v;
        upload_data   = d;
        upload_source = s;
        upload_req    = rq;
        tx_ready      = rdy;
        #1;
        last_acc   = v && upload_ready;
        last_rdy   = upload_ready;
        last_valid = tx_valid;
        if (hold_pending) begin
            checkint("stall_valid_held", int'(tx_valid), 1);
            if (tx_valid) check8("stall_data_stable", tx_data, hold_data);
        end
        hold_pending = 1'b0;
        if (tx_valid) begin
            if (rdy) rxq.push_back(tx_data);
            else begin
                hold_pending = 1'b1;
                hold_data    = tx_data;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] s, input logic [7:0] d);
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            step(1'b1, d, s, 1'b0);
            done = last_acc;
        end
        checkint("send_accept", int'(done), 1);
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            step(1'b0, 8'h00, 8'h00, 1'b0);
            if (last_valid) break;
            n++;
        end
    endtask

    task automatic add_hdr(input logic [7:0] s, input logic [7:0] len);
        expq.push_back(8'hAA);
        expq.push_back(8'h44);
        expq.push_back(s);
        expq.push_back(8'h00);
        expq.push_back(len);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && rxq.size() < expq.size(); k++)
            step(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (25) step(1'b0, 8'h00, 8'h00, 1'b0);
        checkint("frame_len", rxq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (i < rxq.size()) check8($sformatf("frame_byte%0d", i), rxq[i], expq[i]);
        rxq.delete();
        expq.delete();
    endtask

    initial begin
        int gap;
        int seen;

        tbl[0] = '{8'h03, 9, 128'h401F68005600341200, 1'b0, 8'h6F};
        tbl[1] = '{8'h03, 9, 128'h401F68005600341200, 1'b1, 8'h6F};
        tbl[2] = '{8'h07, 1, 128'hFF,                 1'b0, 8'h07};
        tbl[3] = '{8'h03, 4, 128'h80808080,           1'b0, 8'h07};
        tbl[4] = '{8'hF0, 3, 128'h030201,             1'b1, 8'hF9};

        rst_n = 1'b0;
        upload_req = 1'b0;
        upload_valid = 1'b0;
        upload_data = 8'h00;
        upload_source = 8'h00;
        tx_ready = 1'b1;
        #3;
        checkint("reset_tx_valid", int'(tx_valid), 0);
        check8("reset_tx_data", tx_data, 8'h00);
        checkint("reset_upload_ready", int'(upload_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            stall_mode = tbl[i].stall;
            for (int b = 0; b < tbl[i].len; b++) send_byte(tbl[i].src, tbl[i].pay[b]);
            measure_gap(gap);
            checkint("close_gap", gap, 17);
            add_hdr(tbl[i].src, 8'(tbl[i].len));
            for (int b = 0; b < tbl[i].len; b++) expq.push_back(tbl[i].pay[b]);
            expq.push_back(tbl[i].csum);
            drain();
        end
        stall_mode = 1'b0;

        // Full packet closes on count alone.
        for (int b = 0; b < 64; b++) send_byte(8'h03, 8'h01);
        step(1'b1, 8'h01, 8'h03, 1'b0);
        checkint("ready_low_at_max", int'(last_rdy), 0);
        add_hdr(8'h03, 8'h40);
        for (int b = 0; b < 64; b++) expq.push_back(8'h01);
        expq.push_back(8'h83);
        drain();

        // Source change closes the open packet and starts the next.
        send_byte(8'h03, 8'h10);
        send_byte(8'h03, 8'h20);
        send_byte(8'h05, 8'h77);
        measure_gap(gap);
        checkint("second_pkt_gap", gap, 17);
        add_hdr(8'h03, 8'h02);
        expq.push_back(8'h10);
        expq.push_back(8'h20);
        expq.push_back(8'h35);
        add_hdr(8'h05, 8'h01);
        expq.push_back(8'h77);
        expq.push_back(8'h7D);
        drain();

        // upload_req keeps the packet open.
        send_byte(8'h03, 8'hA1);
        send_byte(8'h03, 8'hB2);
        send_byte(8'h03, 8'hC3);
        seen = 0;
        repeat (100) begin
            step(1'b0, 8'h00, 8'h00, 1'b1);
            if (last_valid) seen++;
        end
        checkint("req_holds_open", seen, 0);
        measure_gap(gap);
        checkint("req_release_gap", gap, 17);
        add_hdr(8'h03, 8'h03);
        expq.push_back(8'hA1);
        expq.push_back(8'hB2);
        expq.push_back(8'hC3);
        expq.push_back(8'h1C);
        drain();

        // Reset in the middle of the payload.
        for (int b = 0; b < 9; b++) send_byte(8'h03, tbl[0].pay[b]);
        for (int k = 0; k < 100 && rxq.size() < 6; k++) step(1'b0, 8'h00, 8'h00, 1'b0);
        checkint("reached_payload", int'(rxq.size() >= 6), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkint("midframe_reset_tx_valid", int'(tx_valid), 0);
        check8("midframe_reset_tx_data", tx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rxq.delete();
        hold_pending = 1'b0;
        step(1'b1, 8'h7E, 8'h03, 1'b0);
        checkint("ready_after_reset", int'(last_rdy), 1);
        checkint("accept_after_reset", int'(last_acc), 1);
        measure_gap(gap);
        checkint("post_reset_gap", gap, 17);
        add_hdr(8'h03, 8'h01);
        expq.push_back(8'h7E);
        expq.push_back(8'h82);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
